gcd_operand_sequencer: RTL and testbench
========================================

Name: gcd_operand_sequencer

Overview:
- Upstream stage for the GCD datapath/controller pair.
- Accepts an operand pair over a valid/ready handshake.
- Drives the core's start pulse and presents both operands serially on the shared din bus: A, then B.
- Waits for done, captures the core result and returns it over a valid/ready result handshake with an error code.
- Handles zero operands, which the subtractive core cannot terminate on, and enforces a completion timeout.

Parameters:
- WIDTH, 16, operand/result width (matches core din).
- TIMEOUT, 1024, max cycles in WAIT before declaring a timeout; must be ≥ 2.
- TO_W, $clog2(TIMEOUT+1), timeout counter width (derived, do not override).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  sequencer can accept a pair.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- res_gcd  out  WIDTH  GCD result.
- res_err  out  2  00 ok, 01 both operands zero, 10 timeout.
- gcd_start  out  1  start pulse to core controller.
- gcd_din  out  WIDTH  serial operand bus to core datapath.
- gcd_done  in  1  core completion flag.
- gcd_result  in  WIDTH  core A-register value, valid when gcd_done=1.

Behaviour:
- Reset (rst_n=0 at posedge), from any state including mid-operation:
  - State goes to IDLE.
  - op_ready=0 during the reset cycle, 1 from the first cycle after.
  - res_valid=0, res_gcd=0, res_err=00, gcd_start=0, gcd_din=0, timeout counter=0.
  - A captured pair is discarded. The core is not reset; the next START pulse re-initialises it.
- All outputs are registered.
- States: IDLE, START, LOAD_A, LOAD_B, WAIT, RESP.
- IDLE:
  - op_ready=1. A handshake (op_valid&op_ready) captures op_a/op_b into internal registers.
  - Both zero → RESP, res_gcd=0, res_err=01.
  - Exactly one zero → RESP, res_gcd = the nonzero operand, res_err=00. Core not started.
  - Otherwise → START.
- START: gcd_start=1 for exactly this cycle, gcd_din=0 → LOAD_A.
- LOAD_A: gcd_din=A (core loads A this cycle) → LOAD_B.
- LOAD_B: gcd_din=B → WAIT, counter cleared.
- WAIT:
  - gcd_din holds B. Counter increments each cycle.
  - On gcd_done=1: capture gcd_result into res_gcd, res_err=00 → RESP.
  - If the counter reaches TIMEOUT-1 with gcd_done=0: res_gcd=0, res_err=10 → RESP.
  - If done arrives in the same cycle as the timeout, done wins.
- RESP:
  - res_valid=1. res_gcd and res_err are stable until handshake.
  - On res_ready=1: res_valid drops next cycle → IDLE; op_ready=1 that cycle.
  - A gcd_done pulse while in RESP/IDLE is ignored.
- op_ready=0 in every state except IDLE. Exactly one operation is in flight; no queuing.
- Latency:
  - Nonzero operands: accept → gcd_start = 1 cycle; done sample → res_valid = 1 cycle.
  - Zero bypass: accept → res_valid = 1 cycle.
- gcd_done is sampled only in WAIT. A stuck-high done from a previous run is not seen before LOAD_B completes.

Decomposition:
- Shared package gcd_pkg:
  - State encoding enum (IDLE..RESP).
  - Error code constants ERR_OK=2'b00, ERR_ZERO=2'b01, ERR_TIMEOUT=2'b10.
  - Default WIDTH.
- One natural sub-module: gcd_timeout_ctr, a loadable up-counter with clear, enable and terminal-count flag. Everything else is inline FSM.

Test Plan:
- Pair (17,5), core model returns 1 after 40 cycles → one-cycle gcd_start, gcd_din sequence 17 then 5, res_gcd=1, res_err=00, op_ready=0 throughout.
- Pair (48,18) with res_ready held low 10 cycles after res_valid → res_gcd=6 stable and res_valid held all 10 cycles; op_ready rises only after the handshake.
- Pair (0,9) → no gcd_start, res_valid one cycle after accept, res_gcd=9, res_err=00. Pair (0,0) → res_gcd=0, res_err=01.
- Core stub never asserts done, TIMEOUT=16 → res_valid after 16 WAIT cycles, res_gcd=0, res_err=10. A following pair (12,8) completes normally with 4.
- rst_n low for one cycle during WAIT → all outputs zero next cycle, op_ready=1 after. A subsequent (21,14) yields 7 with a fresh start pulse.
- Back-to-back pairs with op_valid held high and res_ready tied high → second pair accepted exactly one cycle after the first result handshake; never two in flight.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD operand sequencer and its timeout counter.
package gcd_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ZERO    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    LOAD_A = 3'd2,
    LOAD_B = 3'd3,
    WAIT   = 3'd4,
    RESP   = 3'd5
  } gcd_state_e;

endpackage

// File: rtl/gcd_timeout_ctr.sv
// Loadable saturating up-counter; tc flags that the count sits at TIMEOUT-1.
module gcd_timeout_ctr #(
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            ld,
  input  logic [TO_W-1:0] ld_val,
  input  logic            en,
  output logic            tc
);

  localparam logic [TO_W-1:0] TC_VAL = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_r;

  assign tc = (cnt_r == TC_VAL);

  // count register: reset, then clear, then load, then saturating increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {TO_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {TO_W{1'b0}};
    end else if (ld) begin
      cnt_r <= ld_val;
    end else if (en && !tc) begin
      cnt_r <= cnt_r + TO_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/gcd_operand_sequencer.sv
// Feeds an operand pair to the subtractive GCD core (start, A, B on din),
// waits for done or timeout, and hands back the result with an error code.
module gcd_operand_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_gcd,
  output logic [1:0]       res_err,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_din,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result
);

  gcd_state_e       state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             to_tc_s;
  logic             to_clr_s;
  logic             to_ld_s;
  logic             to_en_s;

  assign to_clr_s = (state_r == IDLE);
  assign to_ld_s  = (state_r == LOAD_B);
  assign to_en_s  = (state_r == WAIT);

  gcd_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (to_clr_s),
    .ld     (to_ld_s),
    .ld_val ({TO_W{1'b0}}),
    .en     (to_en_s),
    .tc     (to_tc_s)
  );

  // sequencer FSM with all handshake and core-facing outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      op_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_gcd   <= {WIDTH{1'b0}};
      res_err   <= ERR_OK;
      gcd_start <= 1'b0;
      gcd_din   <= {WIDTH{1'b0}};
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          gcd_start <= 1'b0;
          if (op_valid && op_ready) begin
            a_r      <= op_a;
            b_r      <= op_b;
            op_ready <= 1'b0;
            // the core never terminates on a zero operand, so answer directly
            if ((op_a == {WIDTH{1'b0}}) && (op_b == {WIDTH{1'b0}})) begin
              res_valid <= 1'b1;
              res_gcd   <= {WIDTH{1'b0}};
              res_err   <= ERR_ZERO;
              state_r   <= RESP;
            end else if ((op_a == {WIDTH{1'b0}}) || (op_b == {WIDTH{1'b0}})) begin
              res_valid <= 1'b1;
              res_gcd   <= (op_a == {WIDTH{1'b0}}) ? op_b : op_a;
              res_err   <= ERR_OK;
              state_r   <= RESP;
            end else begin
              gcd_start <= 1'b1;
              gcd_din   <= {WIDTH{1'b0}};
              state_r   <= START;
            end
          end else begin
            op_ready <= 1'b1;
          end
        end
        START: begin
          gcd_start <= 1'b0;
          gcd_din   <= a_r;
          state_r   <= LOAD_A;
        end
        LOAD_A: begin
          gcd_din <= b_r;
          state_r <= LOAD_B;
        end
        LOAD_B: begin
          state_r <= WAIT;
        end
        WAIT: begin
          if (gcd_done) begin
            res_valid <= 1'b1;
            res_gcd   <= gcd_result;
            res_err   <= ERR_OK;
            state_r   <= RESP;
          end else if (to_tc_s) begin
            res_valid <= 1'b1;
            res_gcd   <= {WIDTH{1'b0}};
            res_err   <= ERR_TIMEOUT;
            state_r   <= RESP;
          end else begin
            state_r <= WAIT;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r   <= IDLE;
          op_ready  <= 1'b0;
          res_valid <= 1'b0;
          res_gcd   <= {WIDTH{1'b0}};
          res_err   <= ERR_OK;
          gcd_start <= 1'b0;
          gcd_din   <= {WIDTH{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Scoreboard bench for gcd_operand_sequencer with a behavioural GCD core model.
module tb_gcd_operand_sequencer;
  import gcd_pkg::*;

  localparam int W  = 16;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         op_valid;
  logic         op_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_gcd;
  logic [1:0]   res_err;
  logic         gcd_start;
  logic [W-1:0] gcd_din;
  logic         gcd_done   = 1'b0;
  logic [W-1:0] gcd_result = 16'd0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int core_lat = 40;
  bit b2b      = 1'b0;

  logic [17:0]  sb[$];
  int           acc_cnt = 0, res_cnt = 0, exp_rise = -1, acc_edge = 0, hs_edge = 0;
  int           rst_ph = 0, phase = 0, wcnt = 0;
  bit           hs_pend = 1'b0, prev_rv = 1'b0, prev_start = 1'b0, bypass = 1'b0;
  logic [W-1:0] cur_a = 16'd0, cur_b = 16'd0, ma = 16'd0, mb = 16'd0;

  gcd_operand_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_gcd    (res_gcd),
    .res_err    (res_err),
    .gcd_start  (gcd_start),
    .gcd_din    (gcd_din),
    .gcd_done   (gcd_done),
    .gcd_result (gcd_result)
  );

  always #5 clk = ~clk;

  // posedge counter used for latency checks
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 16'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // core model, scoreboard and protocol monitor, all on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      acc_cnt  = 0;
      res_cnt  = 0;
      exp_rise = -1;
      rst_ph   = 1;
      hs_pend  = 1'b0;
      prev_rv  = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (rst_ph == 1) begin
        check_eq("rst_op_ready", 32'(op_ready), 32'd0);
        check_eq("rst_res_valid", 32'(res_valid), 32'd0);
        check_eq("rst_res_gcd", 32'(res_gcd), 32'd0);
        check_eq("rst_res_err", 32'(res_err), 32'd0);
        check_eq("rst_gcd_start", 32'(gcd_start), 32'd0);
        check_eq("rst_gcd_din", 32'(gcd_din), 32'd0);
        rst_ph = 2;
      end else if (rst_ph == 2) begin
        check_eq("rst_op_ready_after", 32'(op_ready), 32'd1);
        rst_ph = 0;
      end
      if (hs_pend) begin
        check_eq("hs_op_ready", 32'(op_ready), 32'd1);
        check_eq("hs_res_valid_drop", 32'(res_valid), 32'd0);
        hs_pend = 1'b0;
      end
      if (acc_cnt != res_cnt) check_eq("op_ready_busy", 32'(op_ready), 32'd0);
      if (op_valid && op_ready) begin
        check_eq("inflight", 32'(acc_cnt - res_cnt), 32'd0);
        if (b2b && res_cnt > 0) check_eq("b2b_gap", 32'(cyc + 1), 32'(hs_edge + 1));
        cur_a    = op_a;
        cur_b    = op_b;
        acc_edge = cyc + 1;
        acc_cnt++;
        bypass   = (op_a == 16'd0) || (op_b == 16'd0);
        if (bypass) exp_rise = cyc + 1;
      end
      if (gcd_start) begin
        check_eq("start_one_cycle", 32'(prev_start), 32'd0);
        if (!prev_start) begin
          check_eq("start_lat", 32'(cyc), 32'(acc_edge));
          check_eq("start_on_bypass", 32'(bypass), 32'd0);
        end
        check_eq("din_start", 32'(gcd_din), 32'd0);
        phase = 1;
      end else if (phase == 1) begin
        check_eq("din_a", 32'(gcd_din), 32'(cur_a));
        ma = gcd_din;
        phase = 2;
      end else if (phase == 2) begin
        check_eq("din_b", 32'(gcd_din), 32'(cur_b));
        mb = gcd_din;
        phase = 3;
        wcnt = 0;
        exp_rise = (core_lat >= 0 && core_lat <= TO - 1) ? cyc + core_lat + 2 : cyc + TO + 1;
      end else if (phase == 3) begin
        // done stays high once raised, like a core that finished and idles
        if (core_lat >= 0 && wcnt == core_lat) begin
          gcd_done   = 1'b1;
          gcd_result = gcd_ref(ma, mb);
        end else if (wcnt == 0) begin
          gcd_done = 1'b0;
        end
        wcnt++;
      end
      prev_start = gcd_start;
      if (res_valid) begin
        if (!prev_rv) check_eq("res_lat", 32'(cyc), 32'(exp_rise));
        check_eq("op_ready_resp", 32'(op_ready), 32'd0);
        if (sb.size() == 0) begin
          check_eq("sb_size", 32'(sb.size()), 32'd1);
        end else begin
          check_eq("res_gcd", 32'(res_gcd), 32'(sb[0][17:2]));
          check_eq("res_err", 32'(res_err), 32'(sb[0][1:0]));
          if (res_ready) begin
            void'(sb.pop_front());
            res_cnt++;
            hs_edge = cyc + 1;
            hs_pend = 1'b1;
          end
        end
      end
      prev_rv = res_valid;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
    logic [17:0] e;
    bit ok;
    if (a == 16'd0 && b == 16'd0)                  e = {16'd0, ERR_ZERO};
    else if (a == 16'd0 || b == 16'd0)             e = {a | b, ERR_OK};
    else if (core_lat < 0 || core_lat > TO - 1)    e = {16'd0, ERR_TIMEOUT};
    else                                           e = {gcd_ref(a, b), ERR_OK};
    sb.push_back(e);
    op_a = a;
    op_b = b;
    op_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (op_ready) ok = 1'b1;
    end
    check_eq("accept_wait", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    if (!keep) op_valid = 1'b0;
  endtask

  task automatic wait_res(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (res_cnt >= target) ok = 1'b1;
    end
    check_eq("result_wait", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  base;
    bit  seen;
    rst_n     = 1'b0;
    op_valid  = 1'b0;
    op_a      = 16'd0;
    op_b      = 16'd0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    core_lat = 40; base = res_cnt; send(16'd17, 16'd5, 1'b0); wait_res(base + 1);

    // consumer stalls for 10 cycles with the result presented
    res_ready = 1'b0; core_lat = 5; base = res_cnt;
    send(16'd48, 16'd18, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check_eq("stall_res_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check_eq("stall_res_valid", 32'(res_valid), 32'd1);
      check_eq("stall_op_ready", 32'(op_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    wait_res(base + 1);

    base = res_cnt; send(16'd0, 16'd9, 1'b0); wait_res(base + 1);
    base = res_cnt; send(16'd0, 16'd0, 1'b0); wait_res(base + 1);
    base = res_cnt; send(16'd7, 16'd0, 1'b0); wait_res(base + 1);

    core_lat = -1; base = res_cnt; send(16'd3, 16'd6, 1'b0); wait_res(base + 1);
    core_lat = 3;  base = res_cnt; send(16'd12, 16'd8, 1'b0); wait_res(base + 1);
    core_lat = TO - 1; base = res_cnt; send(16'd9, 16'd6, 1'b0); wait_res(base + 1);
    core_lat = TO; base = res_cnt; send(16'd10, 16'd4, 1'b0); wait_res(base + 1);
    core_lat = 2;  base = res_cnt; send(16'd12, 16'd8, 1'b0); wait_res(base + 1);

    // reset pulse while the core is still working
    core_lat = -1;
    send(16'd5, 16'd10, 1'b0);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    core_lat = 4; base = res_cnt; send(16'd21, 16'd14, 1'b0); wait_res(base + 1);

    // back-to-back pairs with op_valid held and res_ready tied high
    core_lat = 6; base = res_cnt;
    send(16'd100, 16'd75, 1'b1);
    b2b = 1'b1;
    send(16'd81, 16'd27, 1'b0);
    wait_res(base + 2);
    b2b = 1'b0;

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
